// File: rtl/float_fmt_pkg.sv
// Shared float format constants and helpers for the float18 <-> float32 path.
// float18 = {sign, exp[5:0] bias 31, mant[10:0]}; float32 = IEEE-754 single.
package float_fmt_pkg;

  localparam int F18_EXP_W = 6;
  localparam int F18_MAN_W = 11;
  localparam int F18_BIAS  = 31;
  localparam int F32_EXP_W = 8;
  localparam int F32_MAN_W = 23;
  localparam int F32_BIAS  = 127;
  // Exponent offset between the two formats (127 - 31).
  localparam int REBIAS    = F32_BIAS - F18_BIAS;

  // Per-lane classification carried from S1 to S2.
  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } lane_class_t;

  // Classify a float18 by its exponent and mantissa fields.
  function automatic lane_class_t classify_f18(input logic [F18_EXP_W-1:0] e,
                                               input logic [F18_MAN_W-1:0] m);
    lane_class_t c;
    if (e == '0)
      c = (m == '0) ? CLS_ZERO : CLS_DENORM;
    else if (e == '1)
      c = (m == '0) ? CLS_INF : CLS_NAN;
    else
      c = CLS_NORMAL;
    return c;
  endfunction

  // Leading-zero count of an 11-bit mantissa; returns 11 for an all-zero input.
  function automatic logic [3:0] lzc11(input logic [F18_MAN_W-1:0] m);
    logic [3:0] n;
    n = 4'd11;
    // Scanning upward, the highest set bit is the last one to write n.
    for (int i = 0; i < F18_MAN_W; i++) begin
      if (m[i]) n = 4'(F18_MAN_W - 1 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/f18_to_f32_lane.sv
// Single-lane float18 -> float32 converter, 3 register stages, all advancing on en.
// S1: register + classify. S2: exponent rebias / denormal normalisation. S3: pack.
// FLOAT18_DENORM_EN: when defined, denormals are normalised exactly; when undefined
// they flush to signed zero and S2 carries no LZC/shift logic.
module f18_to_f32_lane
  import float_fmt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [17:0] din,
  output logic [31:0] dout
);

  logic                 s1_sign_reg;
  logic [F18_EXP_W-1:0] s1_exp_reg;
  logic [F18_MAN_W-1:0] s1_man_reg;
  lane_class_t          s1_cls_reg;

  logic                 s2_sign_reg;
  logic [F32_EXP_W-1:0] s2_exp_reg;
  logic [F18_MAN_W-1:0] s2_man_reg;

  logic [F32_EXP_W-1:0] s2_exp_next;
  logic [F18_MAN_W-1:0] s2_man_next;

  // S1: capture the raw fields and classify the incoming value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sign_reg <= 1'b0;
      s1_exp_reg  <= '0;
      s1_man_reg  <= '0;
      s1_cls_reg  <= CLS_ZERO;
    end else if (en) begin
      s1_sign_reg <= din[17];
      s1_exp_reg  <= din[16:11];
      s1_man_reg  <= din[10:0];
      s1_cls_reg  <= classify_f18(din[16:11], din[10:0]);
    end
  end

`ifdef FLOAT18_DENORM_EN
  logic [3:0] s2_lz;
  assign s2_lz = lzc11(s1_man_reg);
`endif

  // S2 datapath: build the float32 exponent and the top 11 mantissa bits per class.
  always_comb begin
    s2_exp_next = '0;
    s2_man_next = '0;
    unique case (s1_cls_reg)
      CLS_NORMAL: begin
        s2_exp_next = {2'b00, s1_exp_reg} + 8'(REBIAS);
        s2_man_next = s1_man_reg;
      end
      CLS_DENORM: begin
`ifdef FLOAT18_DENORM_EN
        // Shift the leading one out into the hidden bit; the value stays exact.
        s2_exp_next = 8'(REBIAS) - {4'b0000, s2_lz};
        s2_man_next = s1_man_reg << (s2_lz + 4'd1);
`else
        // Flush to signed zero: exponent and mantissa stay at their zero defaults.
        s2_exp_next = '0;
        s2_man_next = '0;
`endif
      end
      CLS_INF: begin
        s2_exp_next = '1;
        s2_man_next = '0;
      end
      CLS_NAN: begin
        // Force the quiet bit, keep the remaining payload bits.
        s2_exp_next = '1;
        s2_man_next = {1'b1, s1_man_reg[9:0]};
      end
      default: begin
        s2_exp_next = '0;
        s2_man_next = '0;
      end
    endcase
  end

  // S2: register the converted fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sign_reg <= 1'b0;
      s2_exp_reg  <= '0;
      s2_man_reg  <= '0;
    end else if (en) begin
      s2_sign_reg <= s1_sign_reg;
      s2_exp_reg  <= s2_exp_next;
      s2_man_reg  <= s2_man_next;
    end
  end

  // S3: pack into the output word; low mantissa bits are always zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (en) begin
      dout <= {s2_sign_reg, s2_exp_reg, s2_man_reg, 12'b0};
    end
  end

endmodule

// File: rtl/float18_to_float32_pair.sv
// Complex float18 pair -> two IEEE-754 singles, fixed 3-cycle latency, valid/ready.
// The whole pipeline shares one enable, so a stalled output freezes every stage.
// FLOAT18_DENORM_EN selects exact denormal handling (see f18_to_f32_lane).
module float18_to_float32_pair
  import float_fmt_pkg::*;
#(
  parameter int PIPE_STAGES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [31:0] re,
  output logic [31:0] im,
  output logic        rdy,
  input  logic        dout_ready
);

  logic                   en;
  logic [PIPE_STAGES-1:0] vld_reg;
  logic [31:0]            lane_out [2];

  // Advance whenever the output slot is empty or being consumed.
  assign en        = !rdy || dout_ready;
  assign din_ready = en;
  assign rdy       = vld_reg[PIPE_STAGES-1];

  // Stage valid shift register, aligned with the lane data stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
    end else if (en) begin
      vld_reg <= {vld_reg[PIPE_STAGES-2:0], din_valid};
    end
  end

  // Lane 0 converts the imaginary half, lane 1 the real half.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    f18_to_f32_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .din   (din[gi*18 +: 18]),
      .dout  (lane_out[gi])
    );
  end

  assign im = lane_out[0];
  assign re = lane_out[1];

endmodule

// File: tb/tb_float18_to_float32_pair.sv
// Testbench for float18_to_float32_pair: vector table, latency, stall, async reset,
// and a random sweep against a behavioural model, scored through an in-order queue.
module tb_float18_to_float32_pair;

  logic        clk;
  logic        rst_n;
  logic [35:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] re;
  logic [31:0] im;
  logic        rdy;
  logic        dout_ready;

  float18_to_float32_pair dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .re         (re),
    .im         (im),
    .rdy        (rdy),
    .dout_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] din;
    logic [31:0] re;
    logic [31:0] im;
  } vec_t;

  vec_t        tbl [8];
  logic [63:0] sb [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_out = 0;

  // Independent model: normalise denormals by shifting until bit 11 is set.
  function automatic logic [31:0] ref_conv(input logic [17:0] x);
    logic       s;
    logic [5:0] e;
    logic [10:0] m;
    logic [11:0] mm;
    int          k;
    s = x[17]; e = x[16:11]; m = x[10:0];
    if (e == 6'd63)
      return (m == 0) ? {s, 8'hFF, 23'd0} : {s, 8'hFF, 1'b1, m[9:0], 12'd0};
    if (e != 0)
      return {s, 8'(e) + 8'd96, m, 12'd0};
    if (m == 0)
      return {s, 31'd0};
`ifdef FLOAT18_DENORM_EN
    mm = {1'b0, m};
    k  = 0;
    while (!mm[11]) begin
      mm = mm << 1;
      k++;
    end
    return {s, 8'(97 - k), mm[10:0], 12'd0};
`else
    mm = '0;
    k  = 0;
    return {s, 31'd0};
`endif
  endfunction

  // Random float18 spread evenly over the five classes.
  function automatic logic [17:0] rand_f18();
    int          c;
    logic        s;
    logic [5:0]  e;
    logic [10:0] m;
    c = $urandom_range(0, 4);
    s = 1'($urandom_range(0, 1));
    m = 11'($urandom_range(0, 2047));
    case (c)
      0: begin e = 6'd0; m = '0; end
      1: begin e = 6'd0; if (m == 0) m = 11'd1; end
      2: e = 6'($urandom_range(1, 62));
      3: begin e = 6'd63; m = '0; end
      default: begin e = 6'd63; if (m == 0) m = 11'd5; end
    endcase
    return {s, e, m};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // One clock: drive at negedge, score the output transfer and the input transfer.
  task automatic cycle(input logic v, input logic [35:0] d, input logic [63:0] expv,
                       input logic dr, output logic acc);
    logic [63:0] e;
    @(negedge clk);
    din_valid  = v;
    din        = d;
    dout_ready = dr;
    #1;
    if (rdy && dout_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        check("unexpected_output", {re, im}, 64'hx);
      end else begin
        e = sb.pop_front();
        $display("out %0d: re=%h im=%h expected %h", n_out, re, im, e);
        check("output_word", {re, im}, e);
      end
    end
    acc = din_valid && din_ready;
    if (acc) sb.push_back(expv);
  endtask

  task automatic idle(input logic dr);
    logic a;
    cycle(1'b0, 36'd0, 64'd0, dr, a);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      idle(1'b1);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [63:0] ref_pair(input logic [35:0] d);
    return {ref_conv(d[35:18]), ref_conv(d[17:0])};
  endfunction

  initial begin
    logic        acc;
    int          idx;
    int          lat;
    int          not_acc;
    logic [63:0] held;
    logic [35:0] d;
    logic [35:0] stream [8];

    tbl[0] = '{36'h0F800_30000 ^ 36'h0, 32'h3F800000, 32'hC0000000};
    tbl[0].din = {18'h0F800, 18'h30000};
    tbl[1] = '{{18'h1F7FF, 18'h1F800}, 32'h4F7FF000, 32'h7F800000};
    tbl[2] = '{{18'h3F801, 18'h20000}, 32'hFFC01000, 32'h80000000};
    tbl[5] = '{{18'h3F800, 18'h1F801}, 32'hFF800000, 32'h7FC01000};
    tbl[7] = '{{18'h3FFFF, 18'h1F400}, 32'hFFFFF000, 32'h4F400000};
`ifdef FLOAT18_DENORM_EN
    tbl[3] = '{{18'h00001, 18'h00400}, 32'h2B000000, 32'h30000000};
    tbl[4] = '{{18'h20001, 18'h00000}, 32'hAB000000, 32'h00000000};
    tbl[6] = '{{18'h00800, 18'h207FF}, 32'h30800000, 32'hB07FE000};
`else
    tbl[3] = '{{18'h00001, 18'h00400}, 32'h00000000, 32'h00000000};
    tbl[4] = '{{18'h20001, 18'h00000}, 32'h80000000, 32'h00000000};
    tbl[6] = '{{18'h00800, 18'h207FF}, 32'h30800000, 32'h80000000};
`endif

    rst_n = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_rdy", {63'd0, rdy}, 64'd0);
    check("reset_re_im", {re, im}, 64'd0);
    check("reset_din_ready", {63'd0, din_ready}, 64'd1);
    rst_n = 1'b1;

    // Latency of one sample with no stall.
    cycle(1'b1, tbl[0].din, {tbl[0].re, tbl[0].im}, 1'b1, acc);
    lat = 0;
    do begin
      lat++;
      idle(1'b1);
    end while (!rdy && lat < 10);
    check("latency", 64'(lat), 64'd3);
    drain();

    // Vector table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].din, {tbl[i].re, tbl[i].im}, 1'b1, acc);
      check("table_accept", {63'd0, acc}, 64'd1);
    end
    drain();

    // 8-sample stream with a 4-cycle output hold mid-stream.
    for (int i = 0; i < 8; i++) stream[i] = {rand_f18(), rand_f18()};
    idx = 0;
    for (int c = 0; c < 40 && (idx < 8 || sb.size() != 0); c++) begin
      logic hold;
      hold = (c >= 5 && c < 9);
      d = stream[idx % 8];
      cycle(idx < 8, d, ref_pair(d), !hold, acc);
      if (acc) idx++;
      if (hold) begin
        check("hold_din_ready", {63'd0, din_ready}, 64'd0);
        if (c == 5) held = {re, im};
        else check("hold_stable", {re, im}, held);
      end
    end
    check("stream_count", 64'(idx), 64'd8);
    drain();

    // Async reset with samples in flight and an output held.
    for (int i = 0; i < 3; i++) begin
      d = stream[i];
      cycle(1'b1, d, ref_pair(d), 1'b0, acc);
    end
    @(negedge clk);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rdy", {63'd0, rdy}, 64'd0);
    check("async_rst_re_im", {re, im}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      check("no_stale_output", {63'd0, rdy}, 64'd0);
    end

    // Full-rate random sweep.
    not_acc = 0;
    for (int i = 0; i < 10000; i++) begin
      d = {rand_f18(), rand_f18()};
      cycle(1'b1, d, ref_pair(d), 1'b1, acc);
      if (!acc) not_acc++;
    end
    check("full_rate", 64'(not_acc), 64'd0);
    drain();

    // Random valid / backpressure mix.
    for (int i = 0; i < 1500; i++) begin
      d = {rand_f18(), rand_f18()};
      cycle(1'($urandom_range(0, 3) != 0), d, ref_pair(d),
            1'($urandom_range(0, 3) != 0), acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
